// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin time-sharing controller for a 4-bit two-operand ALU (optional macro: ALU_DIV0_CHECK_EN)
module alu_share_ctrl #(
    parameter int ALU_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_op,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_data,
    output logic       rsp0_err,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_data,
    output logic       rsp1_err,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    output logic       busy
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Counter value seen on the final WAIT cycle (counter starts at 0 on the first one)
    localparam logic [2:0] LastWait = 3'(ALU_LATENCY - 1);

    state_t     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       owner_q, owner_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] alu_a_q, alu_a_d;
    logic [3:0] alu_b_q, alu_b_d;
    logic [2:0] alu_op_q, alu_op_d;
    logic [7:0] rsp0_data_q, rsp0_data_d;
    logic [7:0] rsp1_data_q, rsp1_data_d;

    logic       grant0, grant1, accept, capture;
    logic [3:0] sel_a, sel_b;
    logic [2:0] sel_op;
    logic [7:0] cap_data;

    // Round-robin grant: only in IDLE; on contention the requester not served last wins
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant_q;
                grant1 = ~last_grant_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;
    assign capture    = (state_q == S_WAIT) && (cnt_q == LastWait);

    assign sel_a  = grant1 ? req1_a  : req0_a;
    assign sel_b  = grant1 ? req1_b  : req0_b;
    assign sel_op = grant1 ? req1_op : req0_op;

`ifdef ALU_DIV0_CHECK_EN
    logic div0_q, div0_d;
    logic rsp0_err_q, rsp0_err_d;
    logic rsp1_err_q, rsp1_err_d;

    // Flag divide-by-zero at accept; replace the ALU result and raise err at capture
    always_comb begin
        div0_d     = div0_q;
        rsp0_err_d = rsp0_err_q;
        rsp1_err_d = rsp1_err_q;
        if (accept) begin
            div0_d = ((sel_op == 3'b100) && (sel_b == 4'd0)) ||
                     ((sel_op == 3'b101) && (sel_a == 4'd0));
        end
        if (capture) begin
            if (owner_q) rsp1_err_d = div0_q;
            else         rsp0_err_d = div0_q;
        end
    end

    // Divide-by-zero flag and per-requester error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div0_q     <= 1'b0;
            rsp0_err_q <= 1'b0;
            rsp1_err_q <= 1'b0;
        end else begin
            div0_q     <= div0_d;
            rsp0_err_q <= rsp0_err_d;
            rsp1_err_q <= rsp1_err_d;
        end
    end

    assign cap_data = div0_q ? 8'hFF : alu_result;
    assign rsp0_err = rsp0_err_q;
    assign rsp1_err = rsp1_err_q;
`else
    assign cap_data = alu_result;
    assign rsp0_err = 1'b0;
    assign rsp1_err = 1'b0;
`endif

    // Sequencer next-state: accept, issue, wait out the ALU latency, respond
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp0_data_d  = rsp0_data_q;
        rsp1_data_d  = rsp1_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    alu_a_d      = sel_a;
                    alu_b_d      = sel_b;
                    alu_op_d     = sel_op;
                    owner_d      = grant1;
                    last_grant_d = grant1;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = 3'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 3'd1;
                if (capture) begin
                    if (owner_q) rsp1_data_d = cap_data;
                    else         rsp0_data_d = cap_data;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cnt_q        <= 3'd0;
            alu_a_q      <= 4'd0;
            alu_b_q      <= 4'd0;
            alu_op_q     <= 3'd0;
            rsp0_data_q  <= 8'd0;
            rsp1_data_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;
    assign rsp0_valid = (state_q == S_RESP) && !owner_q;
    assign rsp1_valid = (state_q == S_RESP) && owner_q;
    assign busy       = (state_q != S_IDLE);

endmodule
